// File: rtl/rinv_qt_multiply.sv
// rinv_qt_multiply
//   Loads Q^T (3x3, Q4.12, row-major) and then requests R^-1 from the
//   upper-triangular inverse stage. It forms A^-1 = R^-1 * Q^T on a single
//   shared MAC and streams the nine results out in row-major order.
//
// Ports
//   CLK, RST_n      clock (rising edge); asynchronous active-low reset
//   start_mult      one-cycle start request, accepted only in IDLE
//   q_data/q_valid  Q^T element stream, row-major, gaps allowed
//   r_mat_inv       R^-1 element stream, one word per cycle after start_inverse
//   done_inverse    completion pulse from the inverse stage
//   start_inverse   one-cycle registered request to the inverse stage
//   a_inv/a_inv_valid  result stream, nine consecutive words
//   done_mult       pulse coinciding with the last a_inv_valid
//   busy            high in every state except IDLE
//   seq_err         sticky protocol error, cleared by reset or an accepted start
module rinv_qt_multiply #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12,
  parameter int ACC_W  = 34
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              start_mult,
  input  logic [DATA_W-1:0] q_data,
  input  logic              q_valid,
  input  logic [DATA_W-1:0] r_mat_inv,
  input  logic              done_inverse,
  output logic              start_inverse,
  output logic [DATA_W-1:0] a_inv,
  output logic              a_inv_valid,
  output logic              done_mult,
  output logic              busy,
  output logic              seq_err
);

  typedef enum logic [2:0] {IDLE, LOAD_Q, REQ_R, FETCH_R, COMPUTE, OUT} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DATA_W-1)));

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
    else                  sat = v[DATA_W-1:0];
  endfunction

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] qt [0:8];
  logic signed [DATA_W-1:0] ri [0:8];
  logic signed [DATA_W-1:0] ob [0:8];

  // cnt is shared: Q word index, fetch edge count, element index, output index
  logic [3:0] cnt;
  logic [1:0] r_idx, c_idx, k_idx;
  logic signed [ACC_W-1:0] acc;

  logic [3:0]                 ri_addr, qt_addr;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, acc_base, acc_sum;

  assign ri_addr  = {2'b00, r_idx} * 4'd3 + {2'b00, k_idx};
  assign qt_addr  = {2'b00, k_idx} * 4'd3 + {2'b00, c_idx};
  assign prod     = ri[ri_addr] * qt[qt_addr];
  assign prod_ext = ACC_W'(prod);
  // accumulator restarts with the first product of every element
  assign acc_base = (k_idx == 2'd0) ? {ACC_W{1'b0}} : acc;
  assign acc_sum  = acc_base + prod_ext;

  assign busy = (state != IDLE);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_mult) state_nxt = LOAD_Q;
      LOAD_Q:  if (q_valid && cnt == 4'd8) state_nxt = REQ_R;
      REQ_R:   state_nxt = FETCH_R;
      FETCH_R: if (cnt == 4'd9) state_nxt = COMPUTE;
      COMPUTE: if (cnt == 4'd8 && k_idx == 2'd2) state_nxt = OUT;
      OUT:     if (cnt == 4'd8) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      start_inverse <= 1'b0;
      a_inv         <= '0;
      a_inv_valid   <= 1'b0;
      done_mult     <= 1'b0;
      seq_err       <= 1'b0;
      cnt           <= '0;
      r_idx         <= '0;
      c_idx         <= '0;
      k_idx         <= '0;
      acc           <= '0;
      for (int n = 0; n < 9; n++) begin
        qt[n] <= '0;
        ri[n] <= '0;
        ob[n] <= '0;
      end
    end else begin
      // start_inverse is high during the cycle after REQ_R, i.e. the first FETCH_R cycle
      start_inverse <= (state == REQ_R);
      a_inv_valid   <= 1'b0;
      done_mult     <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult) begin
            seq_err <= 1'b0;
            cnt     <= '0;
            r_idx   <= '0;
            c_idx   <= '0;
            k_idx   <= '0;
          end
        end
        LOAD_Q: begin
          if (q_valid) begin
            qt[cnt] <= q_data;
            cnt     <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
          end
        end
        REQ_R: cnt <= '0;
        FETCH_R: begin
          // cnt==0 is the edge that samples start_inverse; captures follow on 1..9
          if (cnt != 4'd0) ri[cnt - 4'd1] <= r_mat_inv;
          if (cnt == 4'd9) begin
            if (!done_inverse) seq_err <= 1'b1;
            cnt <= '0;
          end else begin
            if (done_inverse) seq_err <= 1'b1;
            cnt <= cnt + 4'd1;
          end
        end
        COMPUTE: begin
          acc <= acc_sum;
          if (k_idx == 2'd2) begin
            ob[cnt] <= sat(acc_sum >>> FRAC_W);
            k_idx   <= '0;
            cnt     <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
            if (c_idx == 2'd2) begin
              c_idx <= '0;
              r_idx <= r_idx + 2'd1;
            end else begin
              c_idx <= c_idx + 2'd1;
            end
          end else begin
            k_idx <= k_idx + 2'd1;
          end
        end
        OUT: begin
          a_inv       <= ob[cnt];
          a_inv_valid <= 1'b1;
          done_mult   <= (cnt == 4'd8);
          cnt         <= (cnt == 4'd8) ? 4'd0 : cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rinv_qt_multiply.sv
module tb_rinv_qt_multiply;
  localparam int DATA_W = 16;

  logic              CLK = 1'b0;
  logic              RST_n;
  logic              start_mult;
  logic [DATA_W-1:0] q_data;
  logic              q_valid;
  logic [DATA_W-1:0] r_mat_inv;
  logic              done_inverse;
  logic              start_inverse;
  logic [DATA_W-1:0] a_inv;
  logic              a_inv_valid;
  logic              done_mult;
  logic              busy;
  logic              seq_err;

  rinv_qt_multiply #(.DATA_W(16), .FRAC_W(12), .ACC_W(34)) dut (
    .CLK(CLK), .RST_n(RST_n), .start_mult(start_mult), .q_data(q_data),
    .q_valid(q_valid), .r_mat_inv(r_mat_inv), .done_inverse(done_inverse),
    .start_inverse(start_inverse), .a_inv(a_inv), .a_inv_valid(a_inv_valid),
    .done_mult(done_mult), .busy(busy), .seq_err(seq_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int si_count = 0;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (start_inverse) si_count <= si_count + 1;

  logic signed [15:0] tb_qt [9];
  logic signed [15:0] tb_ri [9];
  logic [15:0]        exp_a [9];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: A = floor((R^-1 * Q^T) / 2^12), clamped to the 16-bit signed range
  function automatic void compute_expected();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        longint s;
        s = 0;
        for (int k = 0; k < 3; k++)
          s += longint'(tb_ri[i*3+k]) * longint'(tb_qt[k*3+j]);
        s = s >>> 12;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        exp_a[i*3+j] = s[15:0];
      end
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start_inverse"}, start_inverse, 0);
    chk({tag, "_a_inv"}, a_inv, 0);
    chk({tag, "_a_inv_valid"}, a_inv_valid, 0);
    chk({tag, "_done_mult"}, done_mult, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
  endtask

  // mode 0: normal, 1: done_inverse withheld, 2: early done_inverse, 3: reset mid-COMPUTE
  task automatic run(input int mode, input bit gaps, input bit poke);
    int si0;
    int e_cyc;
    compute_expected();
    si0 = si_count;
    start_mult = 1'b1;
    q_valid = 1'b1;
    q_data = 16'($urandom);
    step();
    start_mult = 1'b0;
    q_valid = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("seq_err_cleared", seq_err, 0);
    for (int n = 0; n < 9; n++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
          start_mult = poke & 1'($urandom_range(0, 1));
          done_inverse = 1'($urandom_range(0, 1));
          q_data = 16'($urandom);
          step();
          start_mult = 1'b0;
          done_inverse = 1'b0;
        end
      end
      q_valid = 1'b1;
      q_data = tb_qt[n];
      step();
      q_valid = 1'b0;
    end
    e_cyc = cyc;
    for (int t = 0; t < 10 && !start_inverse; t++) step();
    chk("start_inverse_seen", start_inverse, 1);
    step();
    for (int n = 0; n < 9; n++) begin
      r_mat_inv = tb_ri[n];
      done_inverse = (n == 8 && mode != 1) || (n == 3 && mode == 2);
      step();
    end
    done_inverse = 1'b0;
    r_mat_inv = 16'($urandom);
    if (mode == 3) begin
      repeat (10) step();
      chk("busy_mid_compute", busy, 1);
      RST_n = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      step();
      step();
      chk_reset_outputs("rst_hold");
      RST_n = 1'b1;
      return;
    end
    for (int t = 0; t < 60 && !a_inv_valid; t++) begin
      start_mult = poke & 1'($urandom_range(0, 1));
      done_inverse = poke & 1'($urandom_range(0, 1));
      step();
      start_mult = 1'b0;
      done_inverse = 1'b0;
    end
    chk("valid_seen", a_inv_valid, 1);
    chk("latency", cyc - e_cyc, 39);
    for (int m = 0; m < 9; m++) begin
      chk($sformatf("a_inv_valid[%0d]", m), a_inv_valid, 1);
      chk($sformatf("a_inv[%0d]", m), a_inv, exp_a[m]);
      chk($sformatf("done_mult[%0d]", m), done_mult, (m == 8));
      step();
    end
    chk("valid_after", a_inv_valid, 0);
    chk("done_after", done_mult, 0);
    chk("a_inv_hold", a_inv, exp_a[8]);
    chk("busy_after", busy, 0);
    chk("seq_err_end", seq_err, (mode == 1 || mode == 2));
    chk("start_inverse_pulses", si_count - si0, 1);
  endtask

  initial begin
    int seen;
    RST_n = 1'b0;
    start_mult = 1'b0;
    q_data = '0;
    q_valid = 1'b0;
    r_mat_inv = '0;
    done_inverse = 1'b0;
    repeat (2) step();
    chk_reset_outputs("reset");
    RST_n = 1'b1;
    step();

    // identity R^-1, ramp Q^T
    for (int n = 0; n < 9; n++) begin
      tb_ri[n] = (n % 4 == 0) ? 16'sh1000 : 16'sh0000;
      tb_qt[n] = 16'(16'h0100 * (n + 1));
    end
    run(0, 0, 0);

    // all 0.5 x 0.5, three products per element
    for (int n = 0; n < 9; n++) begin
      tb_ri[n] = 16'sh0800;
      tb_qt[n] = 16'sh0800;
    end
    run(0, 1, 0);

    // positive and negative saturation of row 0
    for (int n = 0; n < 9; n++) begin
      tb_ri[n] = (n < 3) ? 16'sh7FFF : 16'($urandom);
      tb_qt[n] = 16'sh7FFF;
    end
    run(0, 0, 0);
    for (int n = 0; n < 3; n++) tb_ri[n] = 16'sh8000;
    run(0, 0, 0);

    // done_inverse withheld, then a clean run clears seq_err
    for (int n = 0; n < 9; n++) begin
      tb_ri[n] = 16'($urandom);
      tb_qt[n] = 16'($urandom);
    end
    run(1, 0, 0);
    run(0, 0, 0);

    // early done_inverse
    run(2, 1, 0);

    // random data, gaps, spurious start_mult / done_inverse while busy
    repeat (3) begin
      for (int n = 0; n < 9; n++) begin
        tb_ri[n] = 16'($urandom);
        tb_qt[n] = 16'($urandom);
      end
      run(0, 1, 1);
    end

    // reset mid-COMPUTE, no output afterwards, then a fresh run
    run(3, 0, 0);
    seen = 0;
    repeat (50) begin
      step();
      if (a_inv_valid || busy) seen++;
    end
    chk("no_out_after_rst", seen, 0);
    for (int n = 0; n < 9; n++) begin
      tb_ri[n] = 16'($urandom);
      tb_qt[n] = 16'($urandom);
    end
    run(0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
